// File: rtl/reset_sequencer.sv
// Reset sequencer: holds every domain in reset, then releases them in index order.
// Define RESET_SEQ_TIMEOUT_EN to bound each stage's done-wait and latch a sticky fault.
module reset_sequencer #(
  parameter int unsigned       STAGES      = 4,
  parameter int unsigned       INIT_DELAY  = 15,
  parameter int unsigned       STAGE_DELAY = 2,
  parameter logic [STAGES-1:0] DONE_MASK   = '1,
  parameter int unsigned       TIMEOUT     = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              soft_reset,
  input  logic [STAGES-1:0] stage_done,
  output logic [STAGES-1:0] stage_reset,
  output logic              all_ready,
  output logic              busy,
  output logic              fault
);

  // state    | meaning
  // ST_INIT  | power-on hold, counting INIT_DELAY down
  // ST_WAIT  | stage idx released, waiting for its done (or auto-complete)
  // ST_GAP   | stage idx complete, counting STAGE_DELAY before next release
  // ST_RUN   | all stages released and complete
  // ST_FAULT | a stage timed out; all domains held in reset
  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_GAP   = 3'd2,
    ST_RUN   = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  localparam int unsigned CNT_MAX_A = (INIT_DELAY > STAGE_DELAY) ? INIT_DELAY : STAGE_DELAY;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > TIMEOUT) ? CNT_MAX_A : TIMEOUT;
  localparam int unsigned CNT_W     = ($clog2(CNT_MAX + 1) < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam int unsigned IDX_W     = (STAGES < 2) ? 1 : $clog2(STAGES);

  localparam logic [CNT_W-1:0] INIT_CNT = CNT_W'(INIT_DELAY);
  localparam logic [CNT_W-1:0] GAP_CNT  = CNT_W'(STAGE_DELAY);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STAGES - 1);
`ifdef RESET_SEQ_TIMEOUT_EN
  // Loaded on WAIT entry so the fault fires on the TIMEOUT-th WAIT edge.
  localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(TIMEOUT - 1);
`else
  localparam logic [CNT_W-1:0] WAIT_CNT = '0;
`endif

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    idx_nxt;
  logic [STAGES-1:0]   stage_reset_q, stage_reset_d;
  logic                all_ready_q, all_ready_d;
  logic                fault_q, fault_d;
  logic                stage_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_INIT;
      cnt_q         <= INIT_CNT;
      idx_q         <= '0;
      stage_reset_q <= '1;
      all_ready_q   <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      stage_reset_q <= stage_reset_d;
      all_ready_q   <= all_ready_d;
      fault_q       <= fault_d;
    end
  end

  assign idx_nxt  = idx_q + IDX_W'(1);
  assign stage_ok = stage_done[idx_q] || !DONE_MASK[idx_q];

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    stage_reset_d = stage_reset_q;
    all_ready_d   = all_ready_q;
    fault_d       = fault_q;
    if (soft_reset) begin
      state_d       = ST_INIT;
      cnt_d         = INIT_CNT;
      idx_d         = '0;
      stage_reset_d = '1;
      all_ready_d   = 1'b0;
      fault_d       = 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            stage_reset_d[0] = 1'b0;
            idx_d            = '0;
            cnt_d            = WAIT_CNT;
            state_d          = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (stage_ok) begin
            if (idx_q == LAST_IDX) begin
              state_d     = ST_RUN;
              all_ready_d = 1'b1;
            end else begin
              cnt_d   = GAP_CNT;
              state_d = ST_GAP;
            end
          end
`ifdef RESET_SEQ_TIMEOUT_EN
          else if (cnt_q == '0) begin
            state_d       = ST_FAULT;
            stage_reset_d = '1;
            idx_d         = '0;
            fault_d       = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
`endif
        end
        ST_GAP: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            stage_reset_d[idx_nxt] = 1'b0;
            idx_d                  = idx_nxt;
            cnt_d                  = WAIT_CNT;
            state_d                = ST_WAIT;
          end
        end
        ST_RUN, ST_FAULT: begin
        end
        default: begin
          state_d       = ST_INIT;
          cnt_d         = INIT_CNT;
          idx_d         = '0;
          stage_reset_d = '1;
          all_ready_d   = 1'b0;
          fault_d       = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    busy = (state_q == ST_INIT) || (state_q == ST_WAIT) || (state_q == ST_GAP);
  end

  assign stage_reset = stage_reset_q;
  assign all_ready   = all_ready_q;
`ifdef RESET_SEQ_TIMEOUT_EN
  assign fault       = fault_q;
`else
  assign fault       = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: deadline-based reference model checked every cycle,
// plus directed scenarios with hand-computed edge numbers.
module tb_reset_sequencer;
  localparam int STAGES      = 3;
  localparam int INIT_DELAY  = 4;
  localparam int STAGE_DELAY = 2;
  localparam int TIMEOUT     = 8;
  localparam logic [2:0] DONE_MASK = 3'b101;
`ifdef RESET_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       soft_reset;
  logic [2:0] stage_done;
  logic [2:0] stage_reset;
  logic       all_ready;
  logic       busy;
  logic       fault;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .STAGES(STAGES), .INIT_DELAY(INIT_DELAY), .STAGE_DELAY(STAGE_DELAY),
    .DONE_MASK(DONE_MASK), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .soft_reset(soft_reset), .stage_done(stage_done),
    .stage_reset(stage_reset), .all_ready(all_ready), .busy(busy), .fault(fault)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: edge counter plus the edge at which the next release is due.
  int m_n, m_due, m_rel, m_wstart;
  bit m_wait, m_ready, m_fault;

  task automatic model_reset();
    m_n = 0; m_due = INIT_DELAY + 1; m_rel = 0; m_wstart = 0;
    m_wait = 0; m_ready = 0; m_fault = 0;
  endtask

  task automatic model_step();
    int k;
    if (!reset_n) begin
      model_reset();
      return;
    end
    m_n++;
    if (soft_reset) begin
      m_rel = 0; m_wait = 0; m_ready = 0; m_fault = 0;
      m_due = m_n + INIT_DELAY + 1;
    end else if (m_ready || m_fault) begin
    end else if (m_wait) begin
      k = m_rel - 1;
      if (stage_done[k] || !DONE_MASK[k]) begin
        m_wait = 0;
        if (k == STAGES - 1) m_ready = 1;
        else m_due = m_n + STAGE_DELAY + 1;
      end else if (TO_EN && (m_n - m_wstart) == TIMEOUT) begin
        m_fault = 1; m_rel = 0; m_wait = 0;
      end
    end else if (m_n == m_due) begin
      m_rel++; m_wait = 1; m_wstart = m_n;
    end
  endtask

  function automatic logic [2:0] exp_sr();
    logic [2:0] v = 3'b111;
    for (int i = 0; i < STAGES; i++) if (i < m_rel) v[i] = 1'b0;
    return v;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("model stage_reset", {29'd0, stage_reset}, {29'd0, exp_sr()});
      check("model all_ready", {31'd0, all_ready}, {31'd0, m_ready});
      check("model busy", {31'd0, busy}, {31'd0, !m_ready && !m_fault});
      check("model fault", {31'd0, fault}, {31'd0, m_fault});
    end
  end

  task automatic edges(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic pulse_reset(input logic [2:0] done_val);
    @(negedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    stage_done = done_val;
    reset_n    = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; soft_reset = 1'b0; stage_done = 3'b000;
    edges(3);
    check("por stage_reset", {29'd0, stage_reset}, 32'h7);
    check("por all_ready", {31'd0, all_ready}, 32'h0);
    check("por busy", {31'd0, busy}, 32'h1);

    // Stepwise sequence with a done pulse on stage 0 and stage 2.
    reset_n = 1'b1;
    for (int e = 1; e <= INIT_DELAY; e++) begin
      edges(1);
      check("init hold", {29'd0, stage_reset}, 32'h7);
    end
    edges(1);
    check("stage0 release e5", {29'd0, stage_reset}, 32'h6);
    check("busy after release", {31'd0, busy}, 32'h1);
    edges(2);
    stage_done = 3'b001;
    edges(1);
    stage_done = 3'b000;
    edges(2);
    check("stage1 held e10", {29'd0, stage_reset}, 32'h6);
    edges(1);
    check("stage1 release e11", {29'd0, stage_reset}, 32'h4);
    edges(3);
    check("stage2 held e14", {29'd0, stage_reset}, 32'h4);
    edges(1);
    check("stage2 release e15", {29'd0, stage_reset}, 32'h0);
    edges(1);
    check("not ready e16", {31'd0, all_ready}, 32'h0);
    stage_done = 3'b100;
    edges(1);
    check("ready e17", {31'd0, all_ready}, 32'h1);
    check("idle e17", {31'd0, busy}, 32'h0);
    stage_done = 3'b000;
    edges(5);
    check("run ignores done drop", {31'd0, all_ready}, 32'h1);

    // Asynchronous reset while running.
    #1 reset_n = 1'b0;
    #1;
    check("async stage_reset", {29'd0, stage_reset}, 32'h7);
    check("async all_ready", {31'd0, all_ready}, 32'h0);
    edges(1);

    // All done held from the start.
    stage_done = 3'b111;
    reset_n    = 1'b1;
    edges(13);
    check("all-done not ready e13", {31'd0, all_ready}, 32'h0);
    check("all-done released e13", {29'd0, stage_reset}, 32'h0);
    edges(1);
    check("all-done ready e14", {31'd0, all_ready}, 32'h1);

    // Soft reset while in GAP(0).
    pulse_reset(3'b001);
    edges(6);
    soft_reset = 1'b1;
    edges(1);
    soft_reset = 1'b0;
    check("soft stage_reset", {29'd0, stage_reset}, 32'h7);
    check("soft all_ready", {31'd0, all_ready}, 32'h0);
    check("soft busy", {31'd0, busy}, 32'h1);
    edges(4);
    check("soft re-hold", {29'd0, stage_reset}, 32'h7);
    edges(1);
    check("soft re-release", {29'd0, stage_reset}, 32'h6);
    stage_done = 3'b111;
    edges(20);

    // Soft reset held for three edges from RUN.
    soft_reset = 1'b1;
    edges(3);
    soft_reset = 1'b0;
    check("held soft stage_reset", {29'd0, stage_reset}, 32'h7);
    edges(4);
    check("held soft re-hold", {29'd0, stage_reset}, 32'h7);
    edges(1);
    check("held soft release", {29'd0, stage_reset}, 32'h6);
    edges(12);

    // Stage 0 never reports; done of later stages must be ignored.
    pulse_reset(3'b000);
    edges(5);
    check("stall release", {29'd0, stage_reset}, 32'h6);
    stage_done = 3'b110;
`ifdef RESET_SEQ_TIMEOUT_EN
    edges(7);
    check("no fault e12", {31'd0, fault}, 32'h0);
    edges(1);
    check("fault e13", {31'd0, fault}, 32'h1);
    check("fault stage_reset", {29'd0, stage_reset}, 32'h7);
    check("fault busy", {31'd0, busy}, 32'h0);
    stage_done = 3'b111;
    edges(6);
    check("fault sticky", {31'd0, fault}, 32'h1);
    soft_reset = 1'b1;
    edges(1);
    soft_reset = 1'b0;
    check("fault cleared", {31'd0, fault}, 32'h0);
    check("fault restart busy", {31'd0, busy}, 32'h1);
`else
    edges(30);
    check("no timeout fault", {31'd0, fault}, 32'h0);
    check("still waiting", {29'd0, stage_reset}, 32'h6);
    check("still busy", {31'd0, busy}, 32'h1);
    stage_done = 3'b001;
`endif
    edges(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
